// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-stream boot loader. The CPU is held in reset while a load
// is in progress and released once the image is in place.
module inst_rom_loader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_start_i,
  input  logic [DEPTH_LOG2:0]   load_len_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  input  logic [ADDR_WIDTH-1:0] rom_addr_i,
  input  logic                  rom_enable_i,
  output logic [DATA_WIDTH-1:0] rom_data_o,
  output logic                  cpu_rst_no,
  output logic                  load_busy_o,
  output logic                  load_done_o,
  output logic                  addr_err_o
);

  localparam int unsigned        Words  = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] MaxLen = (DEPTH_LOG2 + 1)'(Words);
  localparam logic [DEPTH_LOG2:0] PtrOne = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StRun} state_e;

  state_e                state_q;
  logic [DEPTH_LOG2:0]   word_ptr_q;
  logic [DEPTH_LOG2:0]   len_q;
  logic [1:0]            byte_cnt_q;
  logic [23:0]           asm_q;
  logic                  byte_ready_q;
  logic                  cpu_rst_nq;
  logic                  load_busy_q;
  logic                  load_done_q;
  logic                  addr_err_q;
  logic [DATA_WIDTH-1:0] mem_q [Words];

  logic                  byte_acc;
  logic                  word_wr;
  logic                  last_word;
  logic                  upper_ok;
  logic                  fetch_hit;
  logic [DEPTH_LOG2-1:0] fetch_idx;
  logic [DEPTH_LOG2:0]   len_clamped;
  logic [1:0]            unused_addr;

  // Bytes are only taken while words remain; a zero-length load accepts nothing.
  assign byte_acc    = (state_q == StLoad) && byte_ready_q && byte_valid_i &&
                       (word_ptr_q != len_q);
  assign word_wr     = byte_acc && (byte_cnt_q == 2'd3);
  assign last_word   = word_wr && ((word_ptr_q + PtrOne) == len_q);
  assign len_clamped = (load_len_i > MaxLen) ? MaxLen : load_len_i;

  assign upper_ok    = (rom_addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);
  assign fetch_idx   = rom_addr_i[DEPTH_LOG2+1:2];
  assign unused_addr = rom_addr_i[1:0];
  assign fetch_hit   = (state_q == StRun) && rom_enable_i && upper_ok;
  assign rom_data_o  = fetch_hit ? mem_q[fetch_idx] : '0;

  assign byte_ready_o = byte_ready_q;
  assign cpu_rst_no   = cpu_rst_nq;
  assign load_busy_o  = load_busy_q;
  assign load_done_o  = load_done_q;
  assign addr_err_o   = addr_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      word_ptr_q   <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      cpu_rst_nq   <= 1'b0;
      load_busy_q  <= 1'b0;
      load_done_q  <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StRun: begin
          if (load_start_i) begin
            state_q      <= StLoad;
            word_ptr_q   <= '0;
            byte_cnt_q   <= '0;
            len_q        <= len_clamped;
            addr_err_q   <= 1'b0;
            cpu_rst_nq   <= 1'b0;
            byte_ready_q <= 1'b1;
            load_busy_q  <= 1'b1;
          end else if ((state_q == StRun) && rom_enable_i && !upper_ok) begin
            addr_err_q <= 1'b1;
          end
        end
        StLoad: begin
          if (byte_acc) begin
            asm_q      <= {asm_q[15:0], byte_data_i};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (word_wr) begin
              word_ptr_q <= word_ptr_q + PtrOne;
            end
          end
          // Leave on the edge that completes the final word so no extra byte is taken.
          if (last_word || (word_ptr_q == len_q)) begin
            state_q      <= StDone;
            byte_ready_q <= 1'b0;
            load_busy_q  <= 1'b0;
            load_done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q     <= StRun;
          load_done_q <= 1'b0;
          cpu_rst_nq  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (word_wr) begin
      mem_q[word_ptr_q[DEPTH_LOG2-1:0]] <= {asm_q, byte_data_i};
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: byte-stream reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_inst_rom_loader;

  logic        clk_i;
  logic        rst_i;
  logic        load_start_i;
  logic [10:0] load_len_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic [31:0] rom_addr_i;
  logic        rom_enable_i;
  logic [31:0] rom_data_o;
  logic        cpu_rst_no;
  logic        load_busy_o;
  logic        load_done_o;
  logic        addr_err_o;

  int checks = 0;
  int errors = 0;

  inst_rom_loader #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DEPTH_LOG2(10)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_start_i (load_start_i),
    .load_len_i   (load_len_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .rom_addr_i   (rom_addr_i),
    .rom_enable_i (rom_enable_i),
    .rom_data_o   (rom_data_o),
    .cpu_rst_no   (cpu_rst_no),
    .load_busy_o  (load_busy_o),
    .load_done_o  (load_done_o),
    .addr_err_o   (addr_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: counts bytes of the current image, commits whole words only.
  bit          m_loading;
  bit          m_done;
  bit          m_run;
  bit          m_err;
  int          m_got;
  int          m_need;
  logic [7:0]  stage [4];
  logic [31:0] ref_mem [1024];
  bit          ref_valid [1024];

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_loading <= 1'b0;
      m_done    <= 1'b0;
      m_run     <= 1'b0;
      m_err     <= 1'b0;
    end else if (m_loading) begin
      if (m_got == m_need) begin
        m_loading <= 1'b0;
        m_done    <= 1'b1;
      end else if (byte_valid_i) begin
        stage[m_got[1:0]] <= byte_data_i;
        m_got             <= m_got + 1;
        if (m_got[1:0] == 2'd3) begin
          ref_mem[m_got[11:2]]   <= {stage[0], stage[1], stage[2], byte_data_i};
          ref_valid[m_got[11:2]] <= 1'b1;
        end
        if (m_got + 1 == m_need) begin
          m_loading <= 1'b0;
          m_done    <= 1'b1;
        end
      end
    end else if (m_done) begin
      m_done <= 1'b0;
      m_run  <= 1'b1;
    end else if (load_start_i) begin
      m_loading <= 1'b1;
      m_run     <= 1'b0;
      m_err     <= 1'b0;
      m_got     <= 0;
      m_need    <= (int'(load_len_i) > 1024) ? 4096 : 4 * int'(load_len_i);
    end else if (m_run && rom_enable_i && (rom_addr_i[31:12] != 20'd0)) begin
      m_err <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] exp_data;
  bit          skip_data;

  always @(negedge clk_i) begin
    exp_data  = 32'd0;
    skip_data = 1'b0;
    if (m_run && rom_enable_i && (rom_addr_i[31:12] == 20'd0)) begin
      if (ref_valid[rom_addr_i[11:2]]) exp_data = ref_mem[rom_addr_i[11:2]];
      else skip_data = 1'b1;
    end
    chk("byte_ready", 32'(byte_ready_o), 32'(m_loading));
    chk("load_busy", 32'(load_busy_o), 32'(m_loading));
    chk("load_done", 32'(load_done_o), 32'(m_done));
    chk("cpu_rst_n", 32'(cpu_rst_no), 32'(m_run));
    chk("addr_err", 32'(addr_err_o), 32'(m_err));
    if (!skip_data) chk("rom_data", rom_data_o, exp_data);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_load(input int len);
    load_len_i   = 11'(len);
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 9) < 3) begin
        byte_valid_i = 1'b0;
        tick();
      end
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    tick();
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_run(input string name);
    for (int i = 0; i < 50 && cpu_rst_no !== 1'b1; i++) tick();
    chk(name, 32'(cpu_rst_no), 32'd1);
  endtask

  logic [7:0] t2_bytes [8];
  logic [7:0] t3_bytes [64];

  initial begin
    t2_bytes = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h12, 8'h34};
    rst_i        = 1'b1;
    load_start_i = 1'b0;
    load_len_i   = '0;
    byte_valid_i = 1'b0;
    byte_data_i  = '0;
    rom_addr_i   = '0;
    rom_enable_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;

    // 1: idle after reset
    repeat (20) tick();
    chk("t1_cpu_rst_n", 32'(cpu_rst_no), 32'd0);
    chk("t1_byte_ready", 32'(byte_ready_o), 32'd0);
    rom_enable_i = 1'b1;
    #1;
    chk("t1_rom_data", rom_data_o, 32'd0);
    rom_enable_i = 1'b0;

    // 2: two-word load
    start_load(2);
    for (int i = 0; i < 8; i++) send_byte(t2_bytes[i], 1'b0);
    chk("t2_done_pulse", 32'(load_done_o), 32'd1);
    chk("t2_held", 32'(cpu_rst_no), 32'd0);
    tick();
    chk("t2_release", 32'(cpu_rst_no), 32'd1);
    chk("t2_done_clear", 32'(load_done_o), 32'd0);
    chk("t2_model_w0", ref_mem[0], 32'h2408_0005);
    chk("t2_model_w1", ref_mem[1], 32'h3C01_1234);
    rom_addr_i   = 32'h4;
    rom_enable_i = 1'b1;
    #1;
    chk("t2_fetch4", rom_data_o, 32'h3C01_1234);
    tick();

    // 4: out-of-range fetch
    rom_addr_i = 32'h0000_1000;
    #1;
    chk("t4_oor_data", rom_data_o, 32'd0);
    tick();
    chk("t4_addr_err", 32'(addr_err_o), 32'd1);
    rom_addr_i   = 32'h0;
    rom_enable_i = 1'b0;
    #1;
    chk("t4_disabled", rom_data_o, 32'd0);
    tick();
    chk("t4_sticky", 32'(addr_err_o), 32'd1);

    // 5: zero-length reload
    start_load(0);
    chk("t5_held", 32'(cpu_rst_no), 32'd0);
    chk("t5_err_clr", 32'(addr_err_o), 32'd0);
    tick();
    chk("t5_done", 32'(load_done_o), 32'd1);
    chk("t5_held2", 32'(cpu_rst_no), 32'd0);
    tick();
    rom_enable_i = 1'b1;
    rom_addr_i   = 32'h0;
    #1;
    chk("t5_keep0", rom_data_o, 32'h2408_0005);
    rom_addr_i = 32'h4;
    #1;
    chk("t5_keep1", rom_data_o, 32'h3C01_1234);
    rom_enable_i = 1'b0;
    tick();

    // 3: 16 words with idle gaps, then readback
    for (int i = 0; i < 64; i++) t3_bytes[i] = 8'($urandom);
    start_load(16);
    for (int i = 0; i < 64; i++) send_byte(t3_bytes[i], 1'b1);
    wait_run("t3_run");
    rom_enable_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rom_addr_i = 32'(i * 4);
      #1;
      chk("t3_readback", rom_data_o,
          {t3_bytes[4*i], t3_bytes[4*i+1], t3_bytes[4*i+2], t3_bytes[4*i+3]});
      tick();
    end
    rom_enable_i = 1'b0;

    // 6: reset mid-load, then a fresh one-word load
    start_load(2);
    for (int i = 0; i < 5; i++) send_byte(t2_bytes[i], 1'b0);
    rst_i = 1'b1;
    #1;
    chk("t6_held", 32'(cpu_rst_no), 32'd0);
    chk("t6_idle", 32'(byte_ready_o), 32'd0);
    chk("t6_busy", 32'(load_busy_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    start_load(1);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    wait_run("t6_run");
    rom_addr_i   = 32'h0;
    rom_enable_i = 1'b1;
    #1;
    chk("t6_fetch0", rom_data_o, 32'hDEAD_BEEF);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
